// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel/line counters, sync pulses, blanking and background colour,
// all registered and packed onto the VGA bus consumed by the downstream overlay stages.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter logic [11:0] BG_RGB    = 12'h8AF,
    localparam int unsigned VGA_BUS_SIZE = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pclk_en,
    output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
    output logic                    hblnk,
    output logic                    vblnk,
    output logic                    frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide; any timing that does not fit must not elaborate.
    generate
        if (H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be below 2048");
        end
    endgenerate

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_start;

    logic        w_h_wrap;
    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic [11:0] w_rgb_nxt;
    logic        w_hblnk_nxt;
    logic        w_vblnk_nxt;
    logic        w_frame_start_nxt;

    // Next counter position and every output decoded from it, so outputs stay skew-free.
    always_comb begin
        w_h_wrap     = (r_hcount == H_LAST);
        w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = (r_vcount == V_LAST) ? 11'd0 : r_vcount + 11'd1;
        end
        w_hblnk_nxt = (w_hcount_nxt >= H_ACT);
        w_vblnk_nxt = (w_vcount_nxt >= V_ACT);
        w_hsync_nxt = ((w_hcount_nxt >= H_SYNC_BEG) && (w_hcount_nxt < H_SYNC_END))
                      ? HSYNC_POL : ~HSYNC_POL;
        w_vsync_nxt = ((w_vcount_nxt >= V_SYNC_BEG) && (w_vcount_nxt < V_SYNC_END))
                      ? VSYNC_POL : ~VSYNC_POL;
        w_rgb_nxt   = (!w_hblnk_nxt && !w_vblnk_nxt) ? BG_RGB : 12'h000;
        w_frame_start_nxt = (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
    end

    // Reset parks on the last pixel of a frame so the first tick lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_rgb         <= 12'h000;
            r_hblnk       <= 1'b1;
            r_vblnk       <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (pclk_en) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_rgb         <= w_rgb_nxt;
            r_hblnk       <= w_hblnk_nxt;
            r_vblnk       <= w_vblnk_nxt;
            r_frame_start <= w_frame_start_nxt;
        end else begin
            // frame_start is a single-clk pulse even when ticks are sparse.
            r_frame_start <= 1'b0;
        end
    end

    assign vga_bus_out = {r_hcount, r_vcount, r_hsync, r_vsync, r_rgb};
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode, a 640x480 negative-polarity mode and a tiny mode
// whose whole frame fits in a short run, all checked every cycle against a pixel-index model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic pclk_en;
    always #5 clk = ~clk;

    logic [35:0] bus0, bus1, bus2;
    logic        hb0, vb0, fs0, hb1, vb1, fs1, hb2, vb2, fs2;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .pclk_en(pclk_en), .vga_bus_out(bus0),
        .hblnk(hb0), .vblnk(vb0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .pclk_en(pclk_en), .vga_bus_out(bus1),
        .hblnk(hb1), .vblnk(vb1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .pclk_en(pclk_en), .vga_bus_out(bus2),
        .hblnk(hb2), .vblnk(vb2), .frame_start(fs2)
    );

    wire [10:0] hc0 = bus0[35:25];
    wire [10:0] vc0 = bus0[24:14];
    wire        hs0 = bus0[13];
    wire [10:0] hc1 = bus1[35:25];
    wire        hs1 = bus1[13];
    wire [10:0] hc2 = bus2[35:25];
    wire        vs2 = bus2[12];
    wire [11:0] rgb2 = bus2[11:0];

    // Timing of the three instances, indexed by instance number.
    localparam int HA_T [3]   = '{800, 640, 8};
    localparam int HFP_T [3]  = '{40, 16, 2};
    localparam int HSW_T [3]  = '{128, 96, 3};
    localparam int HBP_T [3]  = '{88, 48, 3};
    localparam int VA_T [3]   = '{600, 480, 6};
    localparam int VFP_T [3]  = '{1, 10, 1};
    localparam int VSW_T [3]  = '{4, 2, 2};
    localparam int VBP_T [3]  = '{23, 33, 3};
    localparam bit HPOL_T [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit VPOL_T [3] = '{1'b1, 1'b0, 1'b0};

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int htot(input int i);
        return HA_T[i] + HFP_T[i] + HSW_T[i] + HBP_T[i];
    endfunction

    function automatic int vtot(input int i);
        return VA_T[i] + VFP_T[i] + VSW_T[i] + VBP_T[i];
    endfunction

    // Expected {bus, hblnk, vblnk, frame_start} from a linear pixel index within the frame.
    function automatic logic [38:0] model_out(input int i, input int p, input logic f);
        int h, v;
        logic hb, vb, hs, vs;
        logic [11:0] rgb;
        h   = p % htot(i);
        v   = p / htot(i);
        hb  = (h >= HA_T[i]);
        vb  = (v >= VA_T[i]);
        hs  = (h >= HA_T[i] + HFP_T[i] && h < HA_T[i] + HFP_T[i] + HSW_T[i])
              ? HPOL_T[i] : !HPOL_T[i];
        vs  = (v >= VA_T[i] + VFP_T[i] && v < VA_T[i] + VFP_T[i] + VSW_T[i])
              ? VPOL_T[i] : !VPOL_T[i];
        rgb = (!hb && !vb) ? 12'h8AF : 12'h000;
        return {11'(h), 11'(v), hs, vs, rgb, hb, vb, f};
    endfunction

    int   pos [3];
    logic mfs [3];

    // Model: position advances by one pixel per tick and wraps at the frame size.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pos[i] <= htot(i) * vtot(i) - 1;
                mfs[i] <= 1'b0;
            end else if (pclk_en) begin
                pos[i] <= (pos[i] + 1) % (htot(i) * vtot(i));
                mfs[i] <= ((pos[i] + 1) % (htot(i) * vtot(i))) == 0;
            end else begin
                mfs[i] <= 1'b0;
            end
        end
    end

    logic [38:0] act_v [3];
    assign act_v[0] = {bus0, hb0, vb0, fs0};
    assign act_v[1] = {bus1, hb1, vb1, fs1};
    assign act_v[2] = {bus2, hb2, vb2, fs2};

    // Every-cycle comparison of all instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_dut%0d", i), 64'(act_v[i]),
                      64'(model_out(i, pos[i], mfs[i])));
            end
        end
    end

    task automatic cyc(input logic r, input logic en);
        rst     = r;
        pclk_en = en;
        @(negedge clk);
    endtask

    int hs_cnt, rise, vlow, vfirst, stable_bad, fs2_cnt, fs2_wide;
    int first, second, vs_cnt, vb_cnt, rgb_bad, edge_bad;
    logic [37:0] snap;
    logic prev_vs2;
    bit found;

    initial begin
        rst = 1'b1;
        pclk_en = 1'b0;
        cyc(1'b1, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);

        // Reset state
        check("rst_bus", 64'(bus0), 64'({11'd1055, 11'd627, 1'b0, 1'b0, 12'h000}));
        check("rst_flags", 64'({hb0, vb0, fs0}), 64'(3'b110));
        check("rst_bus_vga", 64'(bus1), 64'({11'd799, 11'd524, 1'b1, 1'b1, 12'h000}));

        // First tick lands on (0,0)
        cyc(1'b0, 1'b1);
        check("tick0_bus", 64'(bus0), 64'({11'd0, 11'd0, 1'b0, 1'b0, 12'h8AF}));
        check("tick0_flags", 64'({hb0, vb0, fs0}), 64'(3'b001));
        cyc(1'b0, 1'b0);
        check("idle_fs", 64'(fs0), 64'(0));
        check("idle_hcount", 64'(hc0), 64'(0));

        // One full line at full rate
        hs_cnt = 0; rise = -1; vlow = 0; vfirst = -1;
        for (int k = 1; k <= 1055; k++) begin
            cyc(1'b0, 1'b1);
            if (hb0 && rise < 0) rise = int'(hc0);
            if (hs0) hs_cnt++;
            if (k < 800 && !hs1) begin
                vlow++;
                if (vfirst < 0) vfirst = int'(hc1);
            end
        end
        check("hblnk_rise", 64'(rise), 64'(800));
        check("hsync_width", 64'(hs_cnt), 64'(128));
        check("vga_hsync_width", 64'(vlow), 64'(96));
        check("vga_hsync_first", 64'(vfirst), 64'(656));
        check("pre_wrap", 64'({hc0, vc0}), 64'({11'd1055, 11'd0}));
        cyc(1'b0, 1'b1);
        check("line_wrap", 64'({hc0, vc0}), 64'({11'd0, 11'd1}));

        // One line at quarter rate: outputs hold between ticks
        hs_cnt = 0; stable_bad = 0; fs2_cnt = 0; fs2_wide = 0;
        for (int k = 1; k <= 1056; k++) begin
            cyc(1'b0, 1'b1);
            snap = {bus0, hb0, vb0};
            if (hs0) hs_cnt++;
            if (fs2) fs2_cnt++;
            for (int j = 0; j < 3; j++) begin
                cyc(1'b0, 1'b0);
                if ({bus0, hb0, vb0} !== snap || fs0) stable_bad++;
                if (fs2) fs2_wide++;
            end
        end
        check("qr_hsync_width", 64'(hs_cnt), 64'(128));
        check("qr_stable", 64'(stable_bad), 64'(0));
        check("qr_fs_width", 64'(fs2_wide), 64'(0));
        check("qr_fs_count", 64'(fs2_cnt), 64'(6));
        check("qr_end_pos", 64'({hc0, vc0}), 64'({11'd0, 11'd2}));

        // Full frames of the tiny mode at full rate
        first = -1; second = -1; vs_cnt = 0; vb_cnt = 0; rgb_bad = 0; edge_bad = 0;
        prev_vs2 = vs2;
        for (int k = 1; k <= 420; k++) begin
            cyc(1'b0, 1'b1);
            if (fs2) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (first >= 0 && second < 0) begin
                if (!vs2) vs_cnt++;
                if (vb2) vb_cnt++;
            end
            if ((hb2 || vb2) ? (rgb2 != 12'h000) : (rgb2 != 12'h8AF)) rgb_bad++;
            if (vs2 != prev_vs2 && hc2 != 11'd0) edge_bad++;
            prev_vs2 = vs2;
        end
        check("tiny_first_fs", 64'(first), 64'(192));
        check("tiny_frame_len", 64'(second - first), 64'(192));
        check("tiny_vsync_ticks", 64'(vs_cnt), 64'(32));
        check("tiny_vblnk_ticks", 64'(vb_cnt), 64'(96));
        check("tiny_rgb_blank", 64'(rgb_bad), 64'(0));
        check("tiny_vsync_edges", 64'(edge_bad), 64'(0));

        // Reset in mid-frame
        found = 1'b0;
        for (int k = 0; k < 1100 && !found; k++) begin
            cyc(1'b0, 1'b1);
            if (hc0 == 11'd500) found = 1'b1;
        end
        check("reach_h500", 64'(found), 64'(1));
        cyc(1'b1, 1'b1);
        check("midrst_bus", 64'(bus0), 64'({11'd1055, 11'd627, 1'b0, 1'b0, 12'h000}));
        check("midrst_flags", 64'({hb0, vb0, fs0}), 64'(3'b110));
        cyc(1'b0, 1'b1);
        check("midrst_tick_bus", 64'(bus0), 64'({11'd0, 11'd0, 1'b0, 1'b0, 12'h8AF}));
        check("midrst_tick_flags", 64'({hb0, vb0, fs0}), 64'(3'b001));
        cyc(1'b0, 1'b0);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the VGA pipeline bus.
- Generates pixel/line counters, sync pulses and blanking for one fixed video mode, and packs them onto the VGA bus that the downstream overlay stages consume.
- Drives a parameterised background colour during the active area and black during blanking.
- Sits first in the chain, ahead of all drawing stages.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync
- VSYNC_POL, 1, active level of vsync
- BG_RGB, 12'h8AF, colour driven in the active area

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 628.

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous, active-high reset
- pclk_en, input, 1, pixel tick; counters advance only on cycles where it is high
- vga_bus_out, output, VGA_BUS_SIZE, packed bus {hcount[10:0], vcount[10:0], hsync, vsync, rgb[11:0]} in the standard bus merge order
- hblnk, output, 1, high while hcount >= H_ACTIVE
- vblnk, output, 1, high while vcount >= V_ACTIVE
- frame_start, output, 1, one-cycle pulse when the counters land on (0,0)

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst high at a clk edge, overriding pclk_en):
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - hblnk = 1, vblnk = 1, rgb = 0, frame_start = 0.
  - This is the last pixel of a frame, so the first tick lands on (0,0).
- Cycle with pclk_en = 0 and rst = 0: every output holds its value, except frame_start, which is forced to 0.
- Cycle with pclk_en = 1:
  - hcount_nxt = (hcount == H_TOTAL-1) ? 0 : hcount+1.
  - vcount_nxt advances only when hcount wraps: (vcount == V_TOTAL-1) ? 0 : vcount+1; otherwise it holds.
  - All of hsync, vsync, hblnk, vblnk, rgb and frame_start are decoded from hcount_nxt/vcount_nxt and registered in the same edge. They are therefore aligned with the registered counters, with zero relative skew.
- hsync is at HSYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (defaults 840..967); otherwise it is at the inverse level.
- vsync is at VSYNC_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (defaults 601..604). It is evaluated per line, so vsync edges coincide with hcount = 0.
- rgb = BG_RGB when !hblnk && !vblnk, else 12'h000.
- frame_start = 1 exactly when a tick moves the counters to (0,0). It is cleared on the next clk edge whether or not that cycle has a tick.
- Widths:
  - Counters are 11 bits.
  - Comparisons are unsigned.
  - Parameter sums must be < 2048; elaboration fails otherwise.
- Reset mid-frame: counters return to (H_TOTAL-1, V_TOTAL-1) on that edge. Any partial frame is abandoned; there is no recovery sequencing.
- pclk_en tied high is legal and gives one pixel per clk.

Test Plan:
1. Reset, then a single tick -> hcount=0, vcount=0, frame_start=1, hblnk=0, vblnk=0, rgb=12'h8AF, hsync=0, vsync=0. The next cycle with no tick gives frame_start=0 while hcount stays 0.
2. pclk_en high continuously for one line -> hblnk rises at hcount=800. hsync is high for exactly 128 ticks (hcount 840..967). hcount wraps 1055->0 while vcount increments 0->1 in the same cycle.
3. Run a full frame with pclk_en high -> 1056*628 = 663168 ticks between frame_start pulses. vsync is high for lines 601..604 (4*1056 ticks) with edges at hcount=0. vblnk is high for lines 600..627. rgb is 0 whenever hblnk|vblnk.
4. pclk_en toggling 1-of-4 cycles -> counter sequence identical to test 2 at quarter rate. Outputs are stable on non-tick cycles. frame_start width is 1 clk, not 4.
5. Assert rst at hcount=500, vcount=300 -> next edge gives hcount=1055, vcount=627, rgb=0, syncs inactive. The following tick gives (0,0) with frame_start=1.
6. Override to HSYNC_POL=0, VSYNC_POL=0, H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33 -> H_TOTAL=800, V_TOTAL=525. hsync is low for hcount 656..751. vsync is low for lines 490..491.
